// File: rtl/nms_frame_ctrl.sv
// nms_frame_ctrl -- frame sequencer around a line-buffered non-maximum
// suppression (NMS) stage for a corner detector.
//
// The block accepts one score pixel per clock for a whole frame and forwards
// it, one cycle later, to a downstream NMS buffer. That buffer shifts every
// clock, so any gap in the input stream is fatal to the frame. After the
// last pixel the block feeds zeros so the final rows drain out of the buffer.
// A second counter follows the NMS output stream. It tags each surviving
// corner with its (x, y) position and masks corners in a border of MARGIN
// pixels.
//
// Ports
//   i_clk, i_rst_n     clock (rising edge), async active-low reset
//   i_sof, i_v         start-of-frame (qualified by i_v), pixel valid
//   i_scr, i_is_corner 13-bit corner score and contiguity-test flag
//   o_ready            block accepts pixels (low only while flushing)
//   o_buf_v/scr/corner registered pixel stream to the NMS buffer
//   i_nms_v/corner     NMS result stream
//   o_pt_v/x/y         qualified corner point and its coordinates
//   o_frame_done       one-cycle pulse when the frame has fully drained
//   o_err              sticky frame error (cleared by the next good frame start)
module nms_frame_ctrl #(
  parameter int RES    = 320,
  parameter int ROWS   = 240,
  parameter int MARGIN = 3
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_sof,
  input  logic                    i_v,
  input  logic [12:0]             i_scr,
  input  logic                    i_is_corner,
  output logic                    o_ready,
  output logic                    o_buf_v,
  output logic [12:0]             o_buf_scr,
  output logic                    o_buf_corner,
  input  logic                    i_nms_v,
  input  logic                    i_nms_corner,
  output logic                    o_pt_v,
  output logic [$clog2(RES)-1:0]  o_pt_x,
  output logic [$clog2(ROWS)-1:0] o_pt_y,
  output logic                    o_frame_done,
  output logic                    o_err
);

  localparam int XW        = $clog2(RES);
  localparam int YW        = $clog2(ROWS);
  localparam int FLUSH_MAX = 3 * RES + 8;
  localparam int TW        = $clog2(FLUSH_MAX + 1);

  localparam logic [XW-1:0] X_LAST = XW'(RES - 1);
  localparam logic [YW-1:0] Y_LAST = YW'(ROWS - 1);
  localparam logic [TW-1:0] T_END  = TW'(FLUSH_MAX);
  localparam logic [TW-1:0] T_LAST = TW'(FLUSH_MAX - 1);

  // Border limits, compared as 32-bit unsigned so RES-MARGIN never wraps
  // inside a narrow coordinate width.
  localparam logic [31:0] X_LO = 32'(MARGIN);
  localparam logic [31:0] X_HI = 32'(RES - MARGIN);
  localparam logic [31:0] Y_LO = 32'(MARGIN);
  localparam logic [31:0] Y_HI = 32'(ROWS - MARGIN);

  typedef enum logic [1:0] {
    S_IDLE,
    S_RUN,
    S_FLUSH,
    S_ERR
  } state_t;

  state_t          state, next_state;
  logic [XW-1:0]   in_x, out_x;
  logic [YW-1:0]   in_y, out_y;
  logic            out_full;   // output count has reached RES*ROWS
  logic [TW-1:0]   tmr;        // flush timeout / error drain timer
  logic            frame_start;
  logic            fwd;
  logic            nms_ok;
  logic            in_last;
  logic            pt_hit;

  assign in_last = (in_x == X_LAST) && (in_y == Y_LAST);
  // NMS results are ignored in ERR and once the frame count has saturated.
  assign nms_ok  = i_nms_v && (state != S_ERR) && !out_full;
  assign pt_hit  = nms_ok && i_nms_corner &&
                   (32'(out_x) >= X_LO) && (32'(out_x) < X_HI) &&
                   (32'(out_y) >= Y_LO) && (32'(out_y) < Y_HI);

  always_comb begin
    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch.
    next_state  = state;
    frame_start = 1'b0;
    fwd         = 1'b0;
    unique case (state)
      S_IDLE: begin
        if (i_v && i_sof) begin
          frame_start = 1'b1;
          fwd         = 1'b1;
          next_state  = S_RUN;
        end
      end
      S_RUN: begin
        // The downstream buffer cannot absorb a bubble or a restarted frame.
        if (!i_v || i_sof) begin
          next_state = S_ERR;
        end else begin
          fwd = 1'b1;
          if (in_last) next_state = S_FLUSH;
        end
      end
      S_FLUSH: begin
        if (out_full)           next_state = S_IDLE;
        else if (tmr == T_LAST) next_state = S_ERR;
      end
      S_ERR: begin
        // A new frame is accepted only after the buffer has been drained.
        if ((tmr == T_END) && i_v && i_sof) begin
          frame_start = 1'b1;
          fwd         = 1'b1;
          next_state  = S_RUN;
        end
      end
      default: next_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every register
  // samples pre-edge values, independent of statement order.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state        <= S_IDLE;
      in_x         <= '0;
      in_y         <= '0;
      out_x        <= '0;
      out_y        <= '0;
      out_full     <= 1'b0;
      tmr          <= '0;
      o_buf_v      <= 1'b0;
      o_buf_scr    <= '0;
      o_buf_corner <= 1'b0;
      o_pt_v       <= 1'b0;
      o_pt_x       <= '0;
      o_pt_y       <= '0;
      o_frame_done <= 1'b0;
      o_err        <= 1'b0;
      o_ready      <= 1'b0;
    end else begin
      state <= next_state;

      // Timer restarts on entry to FLUSH or ERR and saturates at FLUSH_MAX.
      if ((next_state != state) &&
          ((next_state == S_FLUSH) || (next_state == S_ERR))) begin
        tmr <= '0;
      end else if (((state == S_FLUSH) || (state == S_ERR)) && (tmr != T_END)) begin
        tmr <= tmr + 1'b1;
      end

      // Input counter holds the position of the next expected pixel.
      if (frame_start) begin
        in_x <= XW'(1);
        in_y <= '0;
      end else if (fwd) begin
        if (in_x == X_LAST) begin
          in_x <= '0;
          in_y <= in_y + 1'b1;
        end else begin
          in_x <= in_x + 1'b1;
        end
      end

      // Output counter follows the NMS stream; it stops at RES*ROWS.
      if (frame_start) begin
        out_x    <= '0;
        out_y    <= '0;
        out_full <= 1'b0;
      end else if (nms_ok) begin
        if (out_x == X_LAST) begin
          out_x <= '0;
          if (out_y == Y_LAST) begin
            out_y    <= '0;
            out_full <= 1'b1;
          end else begin
            out_y <= out_y + 1'b1;
          end
        end else begin
          out_x <= out_x + 1'b1;
        end
      end

      // Buffer sees the accepted pixel, otherwise zeros (flush, error, idle).
      o_buf_v      <= fwd;
      o_buf_scr    <= fwd ? i_scr : '0;
      o_buf_corner <= fwd && i_is_corner;

      o_pt_v <= pt_hit;
      if (pt_hit) begin
        o_pt_x <= out_x;
        o_pt_y <= out_y;
      end

      o_frame_done <= (state == S_FLUSH) && out_full;
      o_err        <= (next_state == S_ERR);
      o_ready      <= (next_state != S_FLUSH);
    end
  end

endmodule

// File: doc/nms_frame_ctrl.md
NMS_FRAME_CTRL -- requirements
Module: nms_frame_ctrl

Interface
REQ-001 Parameter RES, default 320, SHALL be the pixels per row; it SHALL match the RES of the downstream NMS buffer.
REQ-002 Parameter ROWS, default 240, SHALL be the rows per frame.
REQ-003 Parameter MARGIN, default 3, SHALL be the border width in pixels where corners are suppressed.
REQ-004 Localparams SHALL be XW=$clog2(RES), YW=$clog2(ROWS), FLUSH_MAX=3*RES+8.
REQ-005 Ports SHALL be (name, direction, width, meaning):
- i_clk  in  1  sole clock, rising edge.
- i_rst_n  in  1  reset, asynchronous, active-low.
- i_sof  in  1  start of frame; qualified by i_v.
- i_v  in  1  score pixel valid.
- i_scr  in  13  corner score.
- i_is_corner  in  1  contiguity-test result.
- o_ready  out  1  block accepts pixels.
- o_buf_v  out  1  valid to NMS buffer.
- o_buf_scr  out  13  score to NMS buffer.
- o_buf_corner  out  1  corner flag to NMS buffer.
- i_nms_v  in  1  NMS output valid.
- i_nms_corner  in  1  NMS corner result.
- o_pt_v  out  1  corner point valid.
- o_pt_x  out  XW  corner column.
- o_pt_y  out  YW  corner row.
- o_frame_done  out  1  one-cycle end-of-frame pulse.
- o_err  out  1  sticky frame error.

Function
REQ-006 The FSM SHALL have states IDLE, RUN, FLUSH and ERR.
REQ-007 IDLE: o_ready=1; i_v&&i_sof SHALL load in_x=1, in_y=0, forward that pixel and enter RUN; i_v without i_sof SHALL be dropped.
REQ-008 RUN: each i_v pixel SHALL be forwarded registered (1-cycle latency) to o_buf_*; in_x SHALL wrap at RES-1 to 0 and increment in_y.
REQ-009 RUN: acceptance of pixel RES*ROWS-1 SHALL enter FLUSH on the next cycle.
REQ-010 RUN: i_v=0 SHALL enter ERR, because the downstream buffer shifts every clock and does not tolerate gaps.
REQ-011 RUN: i_sof=1 on any pixel other than the first SHALL enter ERR.
REQ-012 FLUSH: o_ready=0; the block SHALL drive o_buf_v=0, o_buf_scr=0, o_buf_corner=0 every cycle to push the last 3*RES+3 centres through the buffer.
REQ-013 FLUSH SHALL end when the output count reaches RES*ROWS: o_frame_done=1 for one cycle, then IDLE.
REQ-014 FLUSH lasting FLUSH_MAX cycles without completion SHALL enter ERR.
REQ-015 Outside FLUSH and RUN forwarding, o_buf_v SHALL be 0, and o_buf_scr and o_buf_corner SHALL be 0.
REQ-016 An output counter (out_x, out_y) SHALL advance on each i_nms_v, in any state except ERR, with the same wrap rule as the input counter; it SHALL be cleared on frame start.
REQ-017 o_pt_v SHALL be registered (1 cycle after i_nms_v) and equal i_nms_v && i_nms_corner && MARGIN<=out_x<RES-MARGIN && MARGIN<=out_y<ROWS-MARGIN.
REQ-018 o_pt_x and o_pt_y SHALL carry the out_x and out_y of the qualifying pixel; they SHALL hold their value when o_pt_v=0.
REQ-019 Counter width rule: compares SHALL be unsigned, and the output count SHALL saturate at RES*ROWS; an extra i_nms_v SHALL be ignored.
REQ-020 ERR: o_err=1, o_ready=1, and pixels SHALL be dropped; the block SHALL drive zeros to the buffer for FLUSH_MAX cycles, then stay in ERR until i_v&&i_sof.
REQ-021 i_v&&i_sof in ERR after that drain SHALL clear o_err and start the frame as in IDLE.
REQ-022 Simultaneous events: the last-pixel acceptance and the final i_nms_v in the same cycle SHALL both be counted; o_frame_done SHALL NOT assert before the FLUSH state.

Reset
REQ-023 i_rst_n=0 SHALL immediately force state IDLE, all counters to 0, and o_buf_v=o_buf_scr=o_buf_corner=0.
REQ-024 During reset, o_pt_v=0, o_pt_x=0, o_pt_y=0, o_frame_done=0, o_err=0 and o_ready=0.
REQ-025 On the first clock after deassertion, o_ready SHALL be 1.
REQ-026 Reset mid-frame SHALL abandon the frame with no o_frame_done pulse.

Verification
REQ-027 RES=8, ROWS=8, 64 gapless pixels starting with i_sof -> o_buf stream equals input delayed 1 cycle; o_frame_done pulses once; o_ready=0 only in FLUSH.
REQ-028 Same frame with a single peak score at (4,4) flagged corner -> exactly one o_pt_v with x=4, y=4.
REQ-029 Corner peaks at (1,4) and (6,6) -> no o_pt_v (border masked).
REQ-030 i_v dropped for 1 cycle at pixel 20 -> o_err=1 on the next cycle; no o_frame_done; next i_sof frame completes normally and o_err clears.
REQ-031 i_rst_n pulsed low at pixel 30 -> all outputs 0 asynchronously; next full frame completes with the correct point count.
REQ-032 i_nms_v held low in FLUSH -> ERR after FLUSH_MAX=32 cycles.
